// File: rtl/hook_line_ctrl_if.sv
// -----------------------------------------------------------------------------
// hook_line_ctrl_if
//   Signal bundle between the input/game logic and the fishing-line controller.
//   master : drives mouse/bait/bite inputs, observes the renderer outputs
//   slave  : the controller itself
// Signals
//   mouse_v    [9:0]  mouse row (0..479)
//   mouse_l           left button level, synchronous to clk
//   bait_req          1-cycle pulse: attach bait
//   bite              1-cycle pulse: a fish touches the hook
//   mode       [1:0]  00 none, 01 bare hook, 10 hook+bait, 11 hook+caught fish
//   hook_v     [9:0]  current hook top row
//   busy              high in any state other than IDLE
//   catch_done        1-cycle pulse when a caught fish reaches the top row
// -----------------------------------------------------------------------------
interface hook_line_ctrl_if;
  logic [9:0] mouse_v;
  logic       mouse_l;
  logic       bait_req;
  logic       bite;
  logic [1:0] mode;
  logic [9:0] hook_v;
  logic       busy;
  logic       catch_done;

  modport master (
    output mouse_v, mouse_l, bait_req, bite,
    input  mode, hook_v, busy, catch_done
  );

  modport slave (
    input  mouse_v, mouse_l, bait_req, bite,
    output mode, hook_v, busy, catch_done
  );
endinterface

// File: rtl/hook_line_ctrl.sv
// -----------------------------------------------------------------------------
// hook_line_ctrl
//   Fishing-line controller upstream of the hook/bait sprite renderer. Owns the
//   cast / fish / reel / catch sequence and produces a sprite mode plus a hook
//   depth that slews toward its target once per movement tick.
// Ports
//   clk   pixel/system clock
//   rst   synchronous, active-high reset
//   bus   hook_line_ctrl_if.slave (mouse_v, mouse_l, bait_req, bite in;
//         mode, hook_v, busy, catch_done out)
// -----------------------------------------------------------------------------
module hook_line_ctrl #(
  parameter int TOP       = 62,
  parameter int BOTTOM    = 460,
  parameter int STEP      = 2,
  parameter int REEL_STEP = 1,
  parameter int TICK_DIV  = 250000
) (
  input  logic              clk,
  input  logic              rst,
  hook_line_ctrl_if.slave   bus
);

  localparam int               CNT_W    = 18;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [9:0]       TOP_V    = 10'(TOP);
  localparam logic [9:0]       BOTTOM_V = 10'(BOTTOM);
  localparam logic [10:0]      STEP_W   = 11'(STEP);
  localparam logic [10:0]      REEL_W   = 11'(REEL_STEP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FISH,
    S_REEL,
    S_CAUGHT
  } state_e;

  typedef enum logic [1:0] {
    MODE_NONE = 2'b00,
    MODE_BARE = 2'b01,
    MODE_BAIT = 2'b10,
    MODE_FISH = 2'b11
  } mode_e;

  // Move cur toward tgt by at most s; lands exactly on tgt when within reach.
  // Done in 11 bits so the difference never wraps.
  function automatic logic [9:0] slew(input logic [9:0]  cur,
                                      input logic [9:0]  tgt,
                                      input logic [10:0] s);
    logic [10:0] c;
    logic [10:0] t;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    if (c > t) slew = ((c - t) <= s) ? tgt : 10'(c - s);
    else       slew = ((t - c) <= s) ? tgt : 10'(c + s);
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;
  logic             mouse_l_q;
  logic             click_q, click_d;
  logic [9:0]       tgt;
  logic [9:0]       follow_v;   // FISH: toward clamped mouse row
  logic [9:0]       reel_v;     // REEL: toward TOP at STEP
  logic [9:0]       land_v;     // CAUGHT: toward TOP at REEL_STEP

  state_e     state_q;
  mode_e      mode_q;
  logic [9:0] hook_v_q;
  logic       busy_q;
  logic       catch_done_q;
  logic       bait_q;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    cnt_d = cnt_q + 1'b1;
    tick  = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      tick  = 1'b1;
    end

    click_d = bus.mouse_l & ~mouse_l_q;

    tgt = bus.mouse_v;
    if (bus.mouse_v < TOP_V)         tgt = TOP_V;
    else if (bus.mouse_v > BOTTOM_V) tgt = BOTTOM_V;

    follow_v = slew(hook_v_q, tgt,   STEP_W);
    reel_v   = slew(hook_v_q, TOP_V, STEP_W);
    land_v   = slew(hook_v_q, TOP_V, REEL_W);
  end

  // Tick divider and click detection. The click is registered, so a press
  // reaches the FSM one edge after it is sampled.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst) begin
      cnt_q     <= '0;
      mouse_l_q <= 1'b0;
      click_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mouse_l_q <= bus.mouse_l;
      click_q   <= click_d;
    end
  end

  // Main sequence; all outputs are registered and updated on the same edge
  // as the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mode_q       <= MODE_NONE;
      hook_v_q     <= TOP_V;
      busy_q       <= 1'b0;
      catch_done_q <= 1'b0;
      bait_q       <= 1'b0;
    end else begin
      catch_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          hook_v_q <= TOP_V;
          if (bus.bait_req) bait_q <= 1'b1;
          if (click_q) begin
            state_q <= S_FISH;
            busy_q  <= 1'b1;
            // A bait_req arriving with the click still counts for this cast.
            mode_q  <= (bait_q | bus.bait_req) ? MODE_BAIT : MODE_BARE;
          end
        end
        S_FISH: begin
          if (tick) hook_v_q <= follow_v;
          // A valid bite takes priority over a simultaneous click.
          if (bus.bite && bait_q) begin
            state_q <= S_CAUGHT;
            mode_q  <= MODE_FISH;
          end else if (click_q) begin
            state_q <= S_REEL;
          end
        end
        S_REEL: begin
          if (tick) hook_v_q <= reel_v;
          if (hook_v_q == TOP_V) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_NONE;
            busy_q  <= 1'b0;
          end
        end
        S_CAUGHT: begin
          if (tick) hook_v_q <= land_v;
          if (hook_v_q == TOP_V) begin
            state_q      <= S_IDLE;
            mode_q       <= MODE_NONE;
            busy_q       <= 1'b0;
            catch_done_q <= 1'b1;
            bait_q       <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          mode_q   <= MODE_NONE;
          hook_v_q <= TOP_V;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mode       = mode_q;
  assign bus.hook_v     = hook_v_q;
  assign bus.busy       = busy_q;
  assign bus.catch_done = catch_done_q;

endmodule

// File: tb/tb_hook_line_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hook_line_ctrl
//   Self-checking bench for hook_line_ctrl with a short tick period. Every
//   cycle is compared against a behavioural model; a vector table and a few
//   directed sequences add fixed expectations for the corner cases.
// -----------------------------------------------------------------------------
module tb_hook_line_ctrl;

  localparam int TOP       = 62;
  localparam int BOTTOM    = 460;
  localparam int STEP      = 2;
  localparam int REEL_STEP = 1;
  localparam int TICK_DIV  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hook_line_ctrl_if bus ();

  hook_line_ctrl #(
    .TOP(TOP), .BOTTOM(BOTTOM), .STEP(STEP),
    .REEL_STEP(REEL_STEP), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {P_IDLE, P_FISH, P_REEL, P_CAUGHT} phase_e;
  phase_e m_phase;
  int     m_hook, m_cycles;
  bit     m_bait, m_prev_l, m_click_pending, m_done;

  function automatic int approach(input int cur, input int tgt, input int s);
    int d = tgt - cur;
    if (d <= s && d >= -s) return tgt;
    return (d > 0) ? cur + s : cur - s;
  endfunction

  function automatic int m_mode();
    case (m_phase)
      P_IDLE:   return 0;
      P_CAUGHT: return 3;
      default:  return m_bait ? 2 : 1;
    endcase
  endfunction

  // One clock edge of the model, given the inputs present before the edge.
  task automatic model_step(input bit r, input int mv, input bit l,
                            input bit br, input bit bt);
    bit tick, click;
    int tgt;
    if (r) begin
      m_phase = P_IDLE; m_hook = TOP; m_bait = 0; m_prev_l = 0;
      m_click_pending = 0; m_done = 0; m_cycles = 0;
      return;
    end
    tick            = (m_cycles % TICK_DIV) == TICK_DIV - 1;
    m_cycles        = m_cycles + 1;
    click           = m_click_pending;      // press seen one edge late
    m_click_pending = l && !m_prev_l;
    m_prev_l        = l;
    m_done          = 0;
    tgt = (mv < TOP) ? TOP : (mv > BOTTOM) ? BOTTOM : mv;
    case (m_phase)
      P_IDLE: begin
        m_hook = TOP;
        if (br) m_bait = 1;
        if (click) m_phase = P_FISH;
      end
      P_FISH: begin
        if (tick) m_hook = approach(m_hook, tgt, STEP);
        if (bt && m_bait) m_phase = P_CAUGHT;
        else if (click)   m_phase = P_REEL;
      end
      P_REEL: begin
        if (m_hook == TOP) m_phase = P_IDLE;
        else if (tick) m_hook = approach(m_hook, TOP, STEP);
      end
      P_CAUGHT: begin
        if (m_hook == TOP) begin
          m_done = 1; m_bait = 0; m_phase = P_IDLE;
        end else if (tick) begin
          m_hook = approach(m_hook, TOP, REEL_STEP);
        end
      end
    endcase
  endtask

  // ---------------- stimulus helpers ----------------
  bit in_rst = 0, in_l = 0, in_br = 0, in_bt = 0;
  int in_mv = 0;

  // Apply current inputs for one edge, compare against the model, then drop
  // the single-cycle pulses.
  task automatic cyc();
    rst          = in_rst;
    bus.mouse_v  = 10'(in_mv);
    bus.mouse_l  = in_l;
    bus.bait_req = in_br;
    bus.bite     = in_bt;
    @(posedge clk);
    model_step(in_rst, in_mv, in_l, in_br, in_bt);
    #1;
    check("model_mode", int'(bus.mode),       m_mode());
    check("model_hook", int'(bus.hook_v),     m_hook);
    check("model_busy", int'(bus.busy),       int'(m_phase != P_IDLE));
    check("model_done", int'(bus.catch_done), int'(m_done));
    in_rst = 0; in_br = 0; in_bt = 0;
  endtask

  // Release then press; leaves the button held and the FSM having acted.
  task automatic press();
    in_l = 0; cyc();
    in_l = 1; cyc();
    cyc();
  endtask

  task automatic wait_hook(input int target, input int budget, input string name);
    int n = 0;
    while (int'(bus.hook_v) != target && n < budget) begin cyc(); n++; end
    check(name, int'(bus.hook_v), target);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (bus.busy !== 1'b0 && n < budget) begin cyc(); n++; end
    check(name, int'(bus.busy), 0);
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (bus.catch_done !== 1'b1 && n < budget) begin cyc(); n++; end
    check(name, int'(bus.catch_done), 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit r; int mv; bit l; bit br; bit bt;
    int e_mode; int e_hook; bit e_busy; bit e_done;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Cast without bait, follow mouse_v=100 at 2 px every 4 cycles; a bite
    // without bait changes nothing.
    vecs[0]  = '{1, 100, 0, 0, 0, 0, 62, 0, 0};
    vecs[1]  = '{0, 100, 1, 0, 0, 0, 62, 0, 0};
    vecs[2]  = '{0, 100, 1, 0, 0, 1, 62, 1, 0};
    vecs[3]  = '{0, 100, 1, 0, 0, 1, 62, 1, 0};
    vecs[4]  = '{0, 100, 1, 0, 0, 1, 64, 1, 0};
    vecs[5]  = '{0, 100, 1, 0, 0, 1, 64, 1, 0};
    vecs[6]  = '{0, 100, 1, 0, 0, 1, 64, 1, 0};
    vecs[7]  = '{0, 100, 1, 0, 0, 1, 64, 1, 0};
    vecs[8]  = '{0, 100, 1, 0, 0, 1, 66, 1, 0};
    vecs[9]  = '{0, 100, 1, 0, 1, 1, 66, 1, 0};
    vecs[10] = '{0, 100, 1, 0, 0, 1, 66, 1, 0};
    vecs[11] = '{0, 100, 1, 0, 0, 1, 66, 1, 0};
    vecs[12] = '{0, 100, 1, 0, 0, 1, 68, 1, 0};

    rst = 1'b1;
    bus.mouse_v = '0; bus.mouse_l = 1'b0; bus.bait_req = 1'b0; bus.bite = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      in_rst = vecs[i].r; in_mv = vecs[i].mv; in_l = vecs[i].l;
      in_br  = vecs[i].br; in_bt = vecs[i].bt;
      cyc();
      check($sformatf("vec%0d_mode", i), int'(bus.mode),       vecs[i].e_mode);
      check($sformatf("vec%0d_hook", i), int'(bus.hook_v),     vecs[i].e_hook);
      check($sformatf("vec%0d_busy", i), int'(bus.busy),       int'(vecs[i].e_busy));
      check($sformatf("vec%0d_done", i), int'(bus.catch_done), int'(vecs[i].e_done));
    end

    // Climb stops at 100; then clamp at the top and bottom limits.
    wait_hook(100, 200, "climb_to_100");
    repeat (40) cyc();
    check("hold_100", int'(bus.hook_v), 100);
    in_mv = 5;
    wait_hook(TOP, 200, "clamp_top");
    repeat (20) cyc();
    check("hold_top", int'(bus.hook_v), TOP);
    in_mv = 479;
    wait_hook(BOTTOM, 1200, "clamp_bottom");
    repeat (20) cyc();
    check("hold_bottom", int'(bus.hook_v), BOTTOM);

    // Reel back empty.
    press();
    check("reel_mode_kept", int'(bus.mode), 1);
    wait_idle(1200, "reel_empty_done");
    check("reel_empty_hook", int'(bus.hook_v), TOP);

    // Baited cast, bite at depth 80, land the fish.
    in_br = 1; cyc();
    check("idle_bait_mode", int'(bus.mode), 0);
    press();
    check("cast_bait_mode", int'(bus.mode), 2);
    in_mv = 80;
    wait_hook(80, 400, "fish_to_80");
    in_bt = 1; cyc();
    check("bite_latency", int'(bus.mode), 3);
    wait_done(400, "catch_done_seen");
    check("catch_mode", int'(bus.mode), 0);
    check("catch_busy", int'(bus.busy), 0);
    check("catch_hook", int'(bus.hook_v), TOP);
    cyc();
    check("catch_pulse_1cyc", int'(bus.catch_done), 0);

    // Recast: bait consumed. Button held across the cast must not reel.
    press();
    check("recast_no_bait", int'(bus.mode), 1);
    in_mv = 300;
    repeat (30) cyc();
    check("held_no_reel_mode", int'(bus.mode), 1);
    check("held_no_reel_deep", int'(bus.hook_v > 10'(TOP)), 1);
    press();
    wait_idle(600, "reel_after_repress");

    // Bait kept across an empty reel; clicks during REEL are ignored.
    in_br = 1; cyc();
    press();
    check("cast2_bait_mode", int'(bus.mode), 2);
    in_mv = 200;
    wait_hook(200, 1000, "fish_to_200");
    press();
    repeat (8) cyc();
    press();
    check("reel_click_busy", int'(bus.busy), 1);
    check("reel_click_mode", int'(bus.mode), 2);
    check("reel_click_moving_up", int'(bus.hook_v < 10'd200), 1);
    wait_idle(1000, "reel_bait_done");
    check("reel_bait_hook", int'(bus.hook_v), TOP);
    press();
    check("bait_kept", int'(bus.mode), 2);

    // Bite and click on the same edge with bait: bite wins.
    in_l = 0; cyc();
    in_l = 1; cyc();
    in_bt = 1; cyc();
    check("bite_beats_click", int'(bus.mode), 3);
    wait_done(1000, "catch2_done_seen");

    // Reset in the middle of a catch at depth 300.
    in_br = 1; cyc();
    press();
    in_mv = 300;
    wait_hook(300, 1500, "fish_to_300");
    in_bt = 1; cyc();
    check("caught_at_300_mode", int'(bus.mode), 3);
    check("caught_at_300_hook", int'(bus.hook_v), 300);
    in_rst = 1; cyc();
    check("rst_mode", int'(bus.mode), 0);
    check("rst_hook", int'(bus.hook_v), TOP);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.catch_done), 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 31) == 0) in_mv = $urandom_range(0, 1023);
      if ($urandom_range(0, 7) == 0)  in_l  = ~in_l;
      in_br  = ($urandom_range(0, 15) == 0);
      in_bt  = ($urandom_range(0, 15) == 0);
      in_rst = ($urandom_range(0, 999) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
